game_flow_ctrl: RTL

Game-level sequencer for the Dino runner. It takes the start/jump button, the frame ticks and the sticky collision flag from the graphics pipeline, and runs the IDLE → RUN → OVER flow. It produces the one-cycle start pulse that re-arms the graphics collision detector, and maintains the BCD score and scroll-speed level consumed by the obstacle and score renderers.

---
 rtl/dino_pkg.sv | 21 ++
 rtl/bcd_counter4.sv | 60 ++++++
 rtl/game_flow_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared definitions for the Dino runner game-level logic: state codes,
// BCD score geometry and default tuning values.
package dino_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_OVER = ST_OVER
    } state_t;

    localparam int DIGIT_W            = 4;
    localparam int SCORE_W            = 16;
    localparam int SPEED_W            = 3;
    localparam int DEF_LOCKOUT_FRAMES = 30;
    localparam int DEF_MAX_SPEED      = 7;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
// o_hundred_carry is combinational and qualifies the increment that rolls the tens digit.
module bcd_counter4
    import dino_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] o_count,
    output logic               o_hundred_carry
);

    logic [DIGIT_W-1:0] d0, d1, d2, d3;
    logic [DIGIT_W-1:0] n0, n1, n2, n3;
    logic               sat;

    assign d0  = o_count[3:0];
    assign d1  = o_count[7:4];
    assign d2  = o_count[11:8];
    assign d3  = o_count[15:12];
    assign sat = (o_count == 16'h9999);

    always_comb begin
        n0 = d0;
        n1 = d1;
        n2 = d2;
        n3 = d3;
        o_hundred_carry = 1'b0;
        if (inc && !sat) begin
            if (d0 != 4'd9) begin
                n0 = d0 + 4'd1;
            end else begin
                n0 = 4'd0;
                if (d1 != 4'd9) begin
                    n1 = d1 + 4'd1;
                end else begin
                    n1 = 4'd0;
                    o_hundred_carry = 1'b1;
                    if (d2 != 4'd9) begin
                        n2 = d2 + 4'd1;
                    end else begin
                        // Not saturated, so the thousands digit is below 9 here.
                        n2 = 4'd0;
                        n3 = d3 + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            o_count <= '0;
        end else begin
            o_count <= {n3, n2, n1, n0};
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Dino runner game sequencer: IDLE -> RUN -> OVER flow, start pulse, BCD score,
// speed level and restart lockout. Optional best-score tracking under `HISCORE_EN.
module game_flow_ctrl
    import dino_pkg::*;
#(
    parameter int LOCKOUT_FRAMES = DEF_LOCKOUT_FRAMES,
    parameter int MAX_SPEED      = DEF_MAX_SPEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_button,
    input  logic               i_game_tick_60hz,
    input  logic               i_game_tick_20hz,
    input  logic               i_collision,
    output logic [1:0]         o_state,
    output logic               o_game_start_pulse,
    output logic               o_freeze,
    output logic [SCORE_W-1:0] o_score,
    output logic [SPEED_W-1:0] o_speed,
    output logic [SCORE_W-1:0] o_hiscore
);

    localparam int LOCK_W = (LOCKOUT_FRAMES > 0) ? $clog2(LOCKOUT_FRAMES + 1) : 1;
    localparam logic [LOCK_W-1:0]  LOCK_LOAD = LOCK_W'(LOCKOUT_FRAMES);
    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);

    logic              btn_sync_p0, btn_sync_p1, btn_edge_p2;
    logic              btn_rise;
    state_t            state, state_nxt;
    logic              start_nxt;
    logic              enter_over;
    logic              score_inc;
    logic              hundred_carry;
    logic [LOCK_W-1:0] lockout;

    // Button synchronizer and edge-detect stages
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
            btn_edge_p2 <= 1'b0;
        end else begin
            btn_sync_p0 <= i_button;
            btn_sync_p1 <= btn_sync_p0;
            btn_edge_p2 <= btn_sync_p1;
        end
    end

    assign btn_rise = btn_sync_p1 & ~btn_edge_p2;

    always_comb begin
        state_nxt  = state;
        start_nxt  = 1'b0;
        enter_over = 1'b0;
        case (state)
            S_IDLE: begin
                if (btn_rise) begin
                    state_nxt = S_RUN;
                    start_nxt = 1'b1;
                end
            end
            S_RUN: begin
                // The previous game's sticky flag is still up during the start pulse.
                if (i_collision && !o_game_start_pulse) begin
                    state_nxt  = S_OVER;
                    enter_over = 1'b1;
                end
            end
            S_OVER: begin
                if (btn_rise && (lockout == '0)) begin
                    state_nxt = S_RUN;
                    start_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            o_game_start_pulse <= 1'b0;
        end else begin
            state              <= state_nxt;
            o_game_start_pulse <= start_nxt;
        end
    end

    assign o_state  = state;
    assign o_freeze = (state != S_RUN);

    // Collision wins over a coincident tick, so the final score is not bumped.
    assign score_inc = (state == S_RUN) && i_game_tick_20hz && !enter_over;

    bcd_counter4 u_score (
        .clk             (clk),
        .rst             (rst),
        .clr             (start_nxt),
        .inc             (score_inc),
        .o_count         (o_score),
        .o_hundred_carry (hundred_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lockout <= '0;
        end else if (enter_over) begin
            lockout <= LOCK_LOAD;
        end else if ((state == S_OVER) && i_game_tick_60hz && (lockout != '0)) begin
            lockout <= lockout - LOCK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_nxt) begin
            o_speed <= SPEED_W'(1);
        end else if (hundred_carry && (o_speed < SPEED_MAX)) begin
            o_speed <= o_speed + SPEED_W'(1);
        end
    end

`ifdef HISCORE_EN
    logic [SCORE_W-1:0] hiscore;

    // Packed BCD orders the same as the decimal value, so a plain compare suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            hiscore <= '0;
        end else if (enter_over && (o_score > hiscore)) begin
            hiscore <= o_score;
        end
    end

    assign o_hiscore = hiscore;
`else
    assign o_hiscore = '0;
`endif

endmodule
